// File: rtl/norm_32bits.sv
// Two-stage leading-zero normalizer with valid/ready handshake on both sides.
// Stage 1 registers the operand and its leading-zero count; stage 2 holds the shifted result.
module norm_32bits #(
    parameter int unsigned EXP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_src,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_src,
    output logic [EXP_W-1:0] out_exp,
    output logic [5:0]       out_shamt,
    output logic             out_zero,
    output logic             out_uflow
);

    // Common width so the exponent/lzc compare works for any EXP_W
    localparam int unsigned CW = (EXP_W > 5) ? EXP_W : 5;

    logic             s1_valid;
    logic [31:0]      s1_src;
    logic [EXP_W-1:0] s1_exp;
    logic [4:0]       s1_lzc;
    logic             s1_zero;

    logic             s1_load;
    logic             s2_load;
    logic [4:0]       lzc_c;
    logic             zero_c;

    logic             uflow_c;
    logic [4:0]       sh_c;
    logic [31:0]      nsrc_c;
    logic [EXP_W-1:0] nexp_c;
    logic [5:0]       nshamt_c;

    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    // Leading-zero count: the highest set bit is the last one to write
    always_comb begin
        lzc_c  = 5'd0;
        zero_c = ~|in_src;
        for (int i = 0; i < 32; i++) begin
            if (in_src[i]) begin
                lzc_c = 5'(31 - i);
            end
        end
    end

    // Shift is limited by the exponent when it cannot absorb the full lzc
    always_comb begin
        uflow_c  = 1'b0;
        sh_c     = 5'd0;
        nsrc_c   = 32'd0;
        nexp_c   = '0;
        nshamt_c = 6'd32;
        if (!s1_zero) begin
            uflow_c  = CW'(s1_exp) < CW'(s1_lzc);
            sh_c     = uflow_c ? 5'(s1_exp) : s1_lzc;
            nsrc_c   = s1_src << sh_c;
            nexp_c   = uflow_c ? '0 : (s1_exp - EXP_W'(s1_lzc));
            nshamt_c = {1'b0, sh_c};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_src    <= 32'd0;
            s1_exp    <= '0;
            s1_lzc    <= 5'd0;
            s1_zero   <= 1'b0;
            out_valid <= 1'b0;
            out_src   <= 32'd0;
            out_exp   <= '0;
            out_shamt <= 6'd0;
            out_zero  <= 1'b0;
            out_uflow <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_src  <= in_src;
                    s1_exp  <= in_exp;
                    s1_lzc  <= lzc_c;
                    s1_zero <= zero_c;
                end
            end
            if (s2_load) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_src   <= nsrc_c;
                    out_exp   <= nexp_c;
                    out_shamt <= nshamt_c;
                    out_zero  <= s1_zero;
                    out_uflow <= uflow_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_norm_32bits.sv
// Bench for norm_32bits: vector table, stall/reset sequences and a random stream,
// all checked through an in-order scoreboard of expected results.
module tb_norm_32bits;

    typedef struct {
        logic [31:0] src;
        logic [7:0]  exp;
        logic [31:0] e_src;
        logic [7:0]  e_exp;
        logic [5:0]  e_shamt;
        logic        e_zero;
        logic        e_uflow;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_src;
    logic [7:0]  in_exp;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_src;
    logic [7:0]  out_exp;
    logic [5:0]  out_shamt;
    logic        out_zero;
    logic        out_uflow;

    int   tests = 0;
    int   fails = 0;
    vec_t q[$];
    vec_t cur;
    vec_t tbl[10];

    logic        hold_v = 1'b0;
    logic [31:0] h_src;
    logic [7:0]  h_exp;
    logic [5:0]  h_shamt;
    logic        h_zero;
    logic        h_uflow;

    norm_32bits #(.EXP_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_src(in_src), .in_exp(in_exp),
        .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src), .out_exp(out_exp),
        .out_shamt(out_shamt), .out_zero(out_zero), .out_uflow(out_uflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    function automatic vec_t model(input logic [31:0] s, input logic [7:0] e);
        vec_t v;
        int   lz;
        v.src = s;
        v.exp = e;
        if (s == 32'd0) begin
            v.e_src = 32'd0; v.e_exp = 8'd0; v.e_shamt = 6'd32; v.e_zero = 1'b1; v.e_uflow = 1'b0;
        end else begin
            lz = 0;
            while (s[31 - lz] == 1'b0) lz++;
            v.e_zero = 1'b0;
            if (int'(e) < lz) begin
                v.e_src = s << e; v.e_exp = 8'd0; v.e_shamt = 6'(e); v.e_uflow = 1'b1;
            end else begin
                v.e_src = s << lz; v.e_exp = e - 8'(lz); v.e_shamt = 6'(lz); v.e_uflow = 1'b0;
            end
        end
        return v;
    endfunction

    // One clock: scoreboard/stability checks at the falling edge, then step past the rising edge
    task automatic cyc();
        vec_t e;
        @(negedge clk);
        if (rst) begin
            q.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_src", out_src, h_src);
                chk("stall_misc", {out_exp, out_shamt, out_zero, out_uflow},
                    {h_exp, h_shamt, h_zero, h_uflow});
            end
            hold_v  = out_valid && !out_ready;
            h_src   = out_src;
            h_exp   = out_exp;
            h_shamt = out_shamt;
            h_zero  = out_zero;
            h_uflow = out_uflow;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 32'(out_valid), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("out_src", out_src, e.e_src);
                    chk("out_exp", 32'(out_exp), 32'(e.e_exp));
                    chk("out_shamt", 32'(out_shamt), 32'(e.e_shamt));
                    chk("out_flags", {out_zero, out_uflow}, {e.e_zero, e.e_uflow});
                end
            end
            if (in_valid && in_ready) q.push_back(cur);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        cur      = v;
        in_src   = v.src;
        in_exp   = v.exp;
        in_valid = 1'b1;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 20 && q.size() > 0; k++) cyc();
        chk(name, 32'(q.size()), 32'd0);
    endtask

    initial begin
        tbl[0] = '{32'h0000_0001, 8'd100, 32'h8000_0000, 8'd69, 6'd31, 1'b0, 1'b0};
        tbl[1] = '{32'h0000_0F00, 8'd10,  32'h003C_0000, 8'd0,  6'd10, 1'b0, 1'b1};
        tbl[2] = '{32'h0000_0000, 8'd55,  32'h0000_0000, 8'd0,  6'd32, 1'b1, 1'b0};
        tbl[3] = '{32'h8000_0000, 8'd0,   32'h8000_0000, 8'd0,  6'd0,  1'b0, 1'b0};
        tbl[4] = '{32'h0001_0000, 8'd20,  32'h8000_0000, 8'd5,  6'd15, 1'b0, 1'b0};
        tbl[5] = '{32'h0001_0000, 8'd15,  32'h8000_0000, 8'd0,  6'd15, 1'b0, 1'b0};
        tbl[6] = '{32'h0001_0000, 8'd14,  32'h4000_0000, 8'd0,  6'd14, 1'b0, 1'b1};
        tbl[7] = '{32'hFFFF_FFFF, 8'd255, 32'hFFFF_FFFF, 8'd255, 6'd0, 1'b0, 1'b0};
        tbl[8] = '{32'h1234_5678, 8'd3,   32'h91A2_B3C0, 8'd0,  6'd3,  1'b0, 1'b0};
        tbl[9] = '{32'h0000_0001, 8'd0,   32'h0000_0001, 8'd0,  6'd0,  1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; in_src = 32'd0; in_exp = 8'd0; out_ready = 1'b1;
        cur = tbl[0];
        repeat (3) cyc();
        rst = 1'b0;
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_src", out_src, 32'd0);
        chk("reset_out_misc", {out_exp, out_shamt, out_zero, out_uflow}, 16'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back table with out_ready held high: one result per cycle, latency 2
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i]);
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        cyc();
        chk("stream_latency", 32'(q.size()), 32'd0);

        // Three operands into a stalled pipeline: only two fit
        out_ready = 1'b0;
        drive(model(32'h0000_00A5, 8'd40)); cyc();
        drive(model(32'h0300_0000, 8'd2));  cyc();
        drive(model(32'h0000_0000, 8'd7));
        chk("full_in_ready", 32'(in_ready), 32'd0);
        repeat (3) cyc();
        chk("full_occupancy", 32'(q.size()), 32'd2);
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        drain("stall_drain");

        // Random stream with random backpressure
        for (int i = 0; i < 300; i++) begin
            logic [31:0] s;
            s = $urandom() >> $urandom_range(31, 0);
            if ($urandom_range(7, 0) == 0) s = 32'd0;
            if (!(in_valid && !in_ready)) begin
                if ($urandom_range(3, 0) != 0) drive(model(s, 8'($urandom_range(255, 0))));
                else in_valid = 1'b0;
            end
            out_ready = ($urandom_range(2, 0) != 0);
            cyc();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain("random_drain");

        // Full pipeline hit by a one-cycle reset: nothing stale may emerge
        out_ready = 1'b0;
        drive(model(32'h0000_0010, 8'd50)); cyc();
        drive(model(32'h0000_0020, 8'd50)); cyc();
        rst = 1'b1;
        cyc();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_pulse_out_valid", 32'(out_valid), 32'd0);
        chk("rst_pulse_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("rst_no_stale", 32'(out_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
